// File: rtl/a_trace_pkg.sv
// Shared types and defaults for the trace RAM capture controller.
// Optional timestamp build: define TRACE_TIMESTAMP_EN.
package a_trace_pkg;
  localparam int ADDR_W     = 13;
  localparam int DATA_W     = 64;
  localparam int FULL_LEVEL = 8183;
  localparam int TS_W       = 16;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_ARMED   = 3'd1,
    S_CAPTURE = 3'd2,
    S_DONE    = 3'd3,
    S_READ    = 3'd4
  } state_t;
endpackage

// File: rtl/a_trace_rd_seq.sv
// Linear readout address generator with rd_valid/rd_last aligned to the
// RAM's registered output.
module a_trace_rd_seq #(
  parameter int ADDR_W = a_trace_pkg::ADDR_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W:0]   count,
  output logic [ADDR_W-1:0] rdaddr,
  output logic              rd_valid,
  output logic              rd_last
);
  localparam logic [ADDR_W:0] ONE = 1;

  logic active;
  logic at_end;

  assign at_end = ({1'b0, rdaddr} == count - ONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      active   <= 1'b0;
      rdaddr   <= '0;
      rd_valid <= 1'b0;
      rd_last  <= 1'b0;
    end else begin
      rd_valid <= active;
      rd_last  <= active && at_end;
      if (start) begin
        active <= 1'b1;
        rdaddr <= '0;
      end else if (active) begin
        if (at_end) active <= 1'b0;
        else        rdaddr <= rdaddr + 1'b1;
      end
    end
  end
endmodule

// File: rtl/a_trace_wr_ctrl.sv
// Trace capture controller in front of the 64x8192 trace RAM.
// Define TRACE_TIMESTAMP_EN to stamp stored words with a 16-bit cycle count.
module a_trace_wr_ctrl
  import a_trace_pkg::*;
#(
  parameter int ADDR_W     = a_trace_pkg::ADDR_W,
  parameter int DATA_W     = a_trace_pkg::DATA_W,
  parameter int FULL_LEVEL = a_trace_pkg::FULL_LEVEL
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              arm,
  input  logic              stop,
  input  logic              trig,
  input  logic              sample_valid,
  input  logic [DATA_W-1:0] sample_data,
  input  logic              rd_start,
  output logic [DATA_W-1:0] ram_din,
  output logic              ram_wen,
  output logic [ADDR_W-1:0] ram_wraddr,
  output logic [ADDR_W-1:0] ram_rdaddr,
  output logic              rd_valid,
  output logic              rd_last,
  output logic [ADDR_W:0]   word_count,
  output logic              full,
  output logic              busy
);
  localparam logic [ADDR_W:0] FULL_CNT = (ADDR_W+1)'(FULL_LEVEL);

  state_t            state;
  logic              arm_take;
  logic              wr_take;
  logic              hit_full;
  logic              rd_go;
  logic [ADDR_W:0]   cnt_inc;
  logic [DATA_W-1:0] wdata;

  assign busy     = (state == S_ARMED) || (state == S_CAPTURE)
                 || (state == S_READ);
  assign arm_take = arm && ((state == S_IDLE) || (state == S_ARMED)
                 || (state == S_DONE));
  // In ARMED, stop outranks arm, which outranks the trigger sample.
  assign wr_take  = sample_valid
                 && (((state == S_ARMED) && trig && !stop && !arm)
                 || (state == S_CAPTURE));
  assign cnt_inc  = word_count + 1'b1;
  assign hit_full = wr_take && (cnt_inc == FULL_CNT);
  assign rd_go    = (state == S_DONE) && !arm && rd_start
                 && (word_count != '0);

`ifdef TRACE_TIMESTAMP_EN
  logic [TS_W-1:0] ts;
  logic [TS_W-1:0] stamp;

  // Stamp counts edges since arm, including the edge that takes the sample.
  assign stamp = ts + 1'b1;
  assign wdata = {stamp, sample_data[DATA_W-TS_W-1:0]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)        ts <= '0;
    else if (arm_take) ts <= '0;
    else if (busy)     ts <= ts + 1'b1;
  end
`else
  assign wdata = sample_data;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      word_count <= '0;
      full       <= 1'b0;
      ram_din    <= '0;
      ram_wen    <= 1'b0;
      ram_wraddr <= '0;
    end else begin
      ram_wen <= 1'b0;
      if (wr_take) begin
        ram_wen    <= 1'b1;
        ram_din    <= wdata;
        ram_wraddr <= word_count[ADDR_W-1:0];
        word_count <= cnt_inc;
      end
      if (arm_take) begin
        word_count <= '0;
        full       <= 1'b0;
      end
      unique case (state)
        S_IDLE: if (arm) state <= S_ARMED;
        S_ARMED: begin
          if (stop)          state <= S_DONE;
          else if (hit_full) begin
            state <= S_DONE;
            full  <= 1'b1;
          end
          else if (wr_take)  state <= S_CAPTURE;
        end
        S_CAPTURE: begin
          if (hit_full) begin
            state <= S_DONE;
            full  <= 1'b1;
          end
          else if (stop) state <= S_DONE;
        end
        S_DONE: begin
          if (arm)        state <= S_ARMED;
          else if (rd_go) state <= S_READ;
        end
        S_READ: if (rd_last) state <= S_DONE;
        default: state <= S_IDLE;
      endcase
    end
  end

  a_trace_rd_seq #(.ADDR_W(ADDR_W)) u_rd_seq (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (rd_go),
    .count    (word_count),
    .rdaddr   (ram_rdaddr),
    .rd_valid (rd_valid),
    .rd_last  (rd_last)
  );
endmodule

// File: tb/tb_a_trace_wr_ctrl.sv
// Scoreboard bench for a_trace_wr_ctrl with a behavioural RAM and a
// queue-based reference model of the capture/readout rules.
module tb_a_trace_wr_ctrl;
  localparam int AW   = 13;
  localparam int DW   = 64;
  localparam int FULL = 8183;

  localparam int M_IDLE  = 0;
  localparam int M_ARMED = 1;
  localparam int M_CAP   = 2;
  localparam int M_DONE  = 3;
  localparam int M_READ  = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          arm = 1'b0;
  logic          stop = 1'b0;
  logic          trig = 1'b0;
  logic          sample_valid = 1'b0;
  logic [DW-1:0] sample_data = '0;
  logic          rd_start = 1'b0;
  logic [DW-1:0] ram_din;
  logic          ram_wen;
  logic [AW-1:0] ram_wraddr;
  logic [AW-1:0] ram_rdaddr;
  logic          rd_valid;
  logic          rd_last;
  logic [AW:0]   word_count;
  logic          full;
  logic          busy;

  always #5 clk = ~clk;

  a_trace_wr_ctrl dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .arm          (arm),
    .stop         (stop),
    .trig         (trig),
    .sample_valid (sample_valid),
    .sample_data  (sample_data),
    .rd_start     (rd_start),
    .ram_din      (ram_din),
    .ram_wen      (ram_wen),
    .ram_wraddr   (ram_wraddr),
    .ram_rdaddr   (ram_rdaddr),
    .rd_valid     (rd_valid),
    .rd_last      (rd_last),
    .word_count   (word_count),
    .full         (full),
    .busy         (busy)
  );

  logic [DW-1:0] mem [0:(1<<AW)-1];
  logic [DW-1:0] dout;

  always @(posedge clk) begin
    if (ram_wen) mem[ram_wraddr] <= ram_din;
    dout <= mem[ram_rdaddr];
  end

  typedef struct {
    int          addr;
    logic [63:0] data;
    int          cyc;
    logic        last;
  } item_t;

  item_t         wq[$];
  item_t         rq[$];
  item_t         mon_e;
  item_t         tmp;
  logic [63:0]   stored[$];
  int            ms = M_IDLE;
  int            rd_left = 0;
  bit            mfull = 1'b0;
  int            cyc = 0;
  int            nvec = 0;
  int            nerr = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h (cycle %0d)",
               name, act, exp, cyc);
    end
  endtask

  initial forever begin
    @(negedge clk);
    if (rst_n) begin
      if (ram_wen === 1'b1) begin
        if (wq.size() == 0) chk("unexpected_wen", 64'd1, 64'd0);
        else begin
          mon_e = wq.pop_front();
          chk("wraddr", 64'(ram_wraddr), 64'(mon_e.addr));
          chk("din", ram_din, mon_e.data);
          chk("wen_cycle", 64'(cyc), 64'(mon_e.cyc));
        end
      end
      if (rd_valid === 1'b1) begin
        if (rq.size() == 0) chk("unexpected_rd_valid", 64'd1, 64'd0);
        else begin
          mon_e = rq.pop_front();
          chk("rd_data", dout, mon_e.data);
          chk("rd_last", 64'(rd_last), 64'(mon_e.last));
          chk("rd_cycle", 64'(cyc), 64'(mon_e.cyc));
        end
      end else if (rd_last !== 1'b0) begin
        chk("stray_rd_last", 64'(rd_last), 64'd0);
      end
    end
  end

  task automatic model_write(input logic [63:0] d);
    tmp.addr = stored.size();
    tmp.data = d;
    tmp.cyc  = cyc;
    tmp.last = 1'b0;
    wq.push_back(tmp);
    stored.push_back(d);
  endtask

  task automatic step(input bit a, input bit s, input bit t, input bit v,
                      input logic [63:0] d, input bit r);
    int n;
    arm = a; stop = s; trig = t; sample_valid = v;
    sample_data = d; rd_start = r;
    @(posedge clk);
    #1;
    case (ms)
      M_IDLE: if (a) begin
        ms = M_ARMED; stored.delete(); mfull = 1'b0;
      end
      M_ARMED: begin
        if (s) begin ms = M_DONE; stored.delete(); end
        else if (a) stored.delete();
        else if (t && v) begin
          model_write(d);
          ms = (stored.size() == FULL) ? M_DONE : M_CAP;
          if (stored.size() == FULL) mfull = 1'b1;
        end
      end
      M_CAP: begin
        if (v) model_write(d);
        if (v && stored.size() == FULL) begin
          ms = M_DONE; mfull = 1'b1;
        end else if (s) ms = M_DONE;
      end
      M_DONE: begin
        if (a) begin
          ms = M_ARMED; stored.delete(); mfull = 1'b0;
        end else if (r && stored.size() > 0) begin
          n = stored.size();
          for (int i = 0; i < n; i++) begin
            tmp.addr = i;
            tmp.data = stored[i];
            tmp.cyc  = cyc + 1 + i;
            tmp.last = (i == n - 1);
            rq.push_back(tmp);
          end
          rd_left = n + 1;
          ms = M_READ;
        end
      end
      default: begin
        rd_left--;
        if (rd_left == 0) ms = M_DONE;
      end
    endcase
    chk("word_count", 64'(word_count), 64'(stored.size()));
    chk("full", 64'(full), 64'(mfull));
    chk("busy", 64'(busy),
        64'(ms == M_ARMED || ms == M_CAP || ms == M_READ));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 64'd0, 0);
  endtask

  function automatic logic [63:0] rnd64();
    return {$urandom, $urandom};
  endfunction

  task automatic do_reset();
    #2;
    rst_n = 1'b0;
    #1;
    chk("reset_outputs",
        64'(|{ram_din, ram_wen, ram_wraddr, ram_rdaddr, rd_valid,
              rd_last, word_count, full, busy}), 64'd0);
    wq.delete(); rq.delete(); stored.delete();
    ms = M_IDLE; mfull = 1'b0; rd_left = 0;
    arm = 0; stop = 0; trig = 0; sample_valid = 0; rd_start = 0;
    @(posedge clk);
    #2;
    rst_n = 1'b1;
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("reset_outputs",
        64'(|{ram_din, ram_wen, ram_wraddr, ram_rdaddr, rd_valid,
              rd_last, word_count, full, busy}), 64'd0);
    rst_n = 1'b1;

    step(1, 0, 0, 0, 64'd0, 0);
    step(0, 0, 1, 1, 64'd1, 0);
    for (int k = 2; k <= 5; k++) step(0, 0, 0, 1, 64'(k), 0);
    step(0, 1, 0, 0, 64'd0, 0);
    step(0, 0, 0, 0, 64'd0, 1);
    idle(8);

    step(1, 0, 0, 0, 64'd0, 0);
    step(0, 0, 1, 1, 64'hA, 0);
    step(0, 0, 0, 1, 64'hB, 0);
    step(0, 0, 0, 1, 64'hC, 0);
    step(0, 1, 0, 1, 64'hD, 0);
    step(0, 0, 0, 0, 64'd0, 1);
    idle(8);

    for (int k = 0; k < 3000; k++)
      step($urandom_range(99) < 3, $urandom_range(99) < 2,
           $urandom_range(99) < 20, $urandom_range(99) < 60,
           rnd64(), $urandom_range(99) < 5);

    do_reset();
    step(1, 0, 0, 0, 64'd0, 0);
    for (int k = 0; k < 100; k++) step(0, 0, 1, 1, rnd64(), 0);
    do_reset();
    step(0, 0, 0, 0, 64'd0, 1);
    idle(4);

    step(1, 0, 0, 0, 64'd0, 0);
    for (int k = 0; k < FULL + 6; k++) step(0, 0, 1, 1, rnd64(), 0);
    step(0, 0, 0, 0, 64'd0, 1);
    idle(FULL + 6);

    step(1, 0, 0, 0, 64'd0, 0);
    for (int k = 0; k < 400; k++)
      step($urandom_range(99) < 2, $urandom_range(99) < 3,
           $urandom_range(99) < 30, $urandom_range(99) < 70,
           rnd64(), $urandom_range(99) < 6);
    idle(600);

    chk("wq_empty", 64'(wq.size()), 64'd0);
    chk("rq_empty", 64'(rq.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
